// File: rtl/write_back_stage.sv
// write_back_stage: frame-synchronous register-file write-back with miss tracking
module write_back_stage #(
  parameter int          FRAME_LEN    = 5,
  parameter int          SLOT         = 4,
  parameter int          ZERO_REG     = 31,
  parameter logic [31:0] MISS_PATTERN = 32'hDEAD_BEEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        memToReg,
  input  logic        regWrite,
  input  logic [4:0]  writeReg,
  input  logic [31:0] aluResult,
  input  logic [31:0] memData,
  output logic        rfWriteEn,
  output logic [4:0]  rfWriteAddr,
  output logic [31:0] rfWriteData,
  output logic        missFlag,
  output logic [15:0] commitCount
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] COMMIT = 1'b1;

  logic [0:0] state;
  logic [2:0] frame_count;
  logic       held_write;
  logic       sample;

  assign sample    = state == IDLE && frame_count == 3'(SLOT) && !stall;
  assign rfWriteEn = state == COMMIT && held_write && rfWriteAddr != 5'(ZERO_REG);

  // Frame counter freezes under stall and wraps at the end of the frame
  always_ff @(posedge clock)
    if (!reset_n) frame_count <= 3'd0;
    else if (!stall) frame_count <= frame_count == 3'(FRAME_LEN - 1) ? 3'd0 : frame_count + 3'd1;

  // COMMIT lasts exactly one cycle after each sampling edge, regardless of stall
  always_ff @(posedge clock)
    if (!reset_n) state <= IDLE;
    else state <= sample ? COMMIT : IDLE;

  // Capture the instruction at the sampling edge; address and data double as the held values
  always_ff @(posedge clock)
    if (!reset_n) begin
      held_write  <= 1'b0;
      rfWriteAddr <= 5'd0;
      rfWriteData <= 32'd0;
    end else if (sample) begin
      held_write  <= regWrite;
      rfWriteAddr <= writeReg;
      rfWriteData <= memToReg ? memData : aluResult;
    end

  // Sticky miss flag; memData is only looked at for loads
  always_ff @(posedge clock)
    if (!reset_n) missFlag <= 1'b0;
    else if (sample && memToReg && memData == MISS_PATTERN) missFlag <= 1'b1;

  // Saturating count of strobed register writes
  always_ff @(posedge clock)
    if (!reset_n) commitCount <= 16'd0;
    else if (rfWriteEn && commitCount != 16'hFFFF) commitCount <= commitCount + 16'd1;
endmodule

// File: tb/tb_write_back_stage.sv
// tb_write_back_stage: directed and randomized checks of write_back_stage against a frame-level model
module tb_write_back_stage;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        memToReg = 1'b0;
  logic        regWrite = 1'b0;
  logic [4:0]  writeReg = 5'd0;
  logic [31:0] aluResult = 32'd0;
  logic [31:0] memData = 32'd0;
  logic        rfWriteEn;
  logic [4:0]  rfWriteAddr;
  logic [31:0] rfWriteData;
  logic        missFlag;
  logic [15:0] commitCount;

  int compared = 0;
  int mismatched = 0;

  int          m_fc = 0;
  bit          m_commit = 0;
  bit          m_en = 0;
  bit          m_miss = 0;
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_data = 32'd0;
  int          m_cnt = 0;

  always #5 clock = ~clock;

  write_back_stage dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .memToReg(memToReg),
    .regWrite(regWrite), .writeReg(writeReg), .aluResult(aluResult), .memData(memData),
    .rfWriteEn(rfWriteEn), .rfWriteAddr(rfWriteAddr), .rfWriteData(rfWriteData),
    .missFlag(missFlag), .commitCount(commitCount)
  );

  task automatic step();
    @(posedge clock);
    if (!reset_n) begin
      m_fc = 0; m_commit = 0; m_en = 0; m_miss = 0; m_addr = 5'd0; m_data = 32'd0; m_cnt = 0;
    end else begin
      if (m_en && m_cnt < 65535) m_cnt++;
      m_en = 0;
      if (!m_commit && m_fc == 4 && !stall) begin
        m_commit = 1;
        m_addr = writeReg;
        m_data = memToReg ? memData : aluResult;
        if (memToReg && memData == 32'hDEAD_BEEF) m_miss = 1;
        m_en = regWrite && writeReg != 5'd31;
      end else m_commit = 0;
      if (!stall) m_fc = (m_fc + 1) % 5;
    end
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; memToReg = 0; regWrite = 0; writeReg = 5'd0; aluResult = 32'd0; memData = 32'd0;
  endtask

  task automatic run_to_slot();
    int n = 0;
    idle_inputs();
    while (m_fc != 4 && n < 10) begin step(); n++; end
    if (m_fc != 4) begin
      mismatched++;
      $display("FAIL run_to_slot: frame position %0d after %0d cycles, required 4", m_fc, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 0; stall = 1; regWrite = 1; writeReg = 5'd4; aluResult = 32'h1234;
    step(); step();
    compared++;
    if ({rfWriteEn, rfWriteAddr, rfWriteData, missFlag, commitCount} !== 55'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h miss=%b cnt=%0d, required all zero",
               rfWriteEn, rfWriteAddr, rfWriteData, missFlag, commitCount);
    end
    idle_inputs();
    reset_n = 1;
  endtask

  task automatic test_alu_writeback();
    run_to_slot();
    regWrite = 1; writeReg = 5'd5; aluResult = 32'h0000_0042; memData = 32'hzzzz_zzzz;
    step();
    compared++;
    if ({rfWriteEn, rfWriteAddr, rfWriteData} !== {1'b1, 5'd5, 32'h42}) begin
      mismatched++;
      $display("FAIL alu_wb: got en=%b addr=%0d data=%h, required en=1 addr=5 data=00000042",
               rfWriteEn, rfWriteAddr, rfWriteData);
    end
    idle_inputs();
    step();
    compared++;
    if (rfWriteEn !== 1'b0 || commitCount !== 16'd1) begin
      mismatched++;
      $display("FAIL alu_wb_after: got en=%b cnt=%0d, required en=0 cnt=1", rfWriteEn, commitCount);
    end
    compared++;
    if (rfWriteAddr !== 5'd5 || rfWriteData !== 32'h42 || missFlag !== 1'b0) begin
      mismatched++;
      $display("FAIL alu_wb_hold: got addr=%0d data=%h miss=%b, required 5 00000042 0",
               rfWriteAddr, rfWriteData, missFlag);
    end
  endtask

  task automatic test_load_hit();
    logic [15:0] c0;
    run_to_slot();
    c0 = commitCount;
    memToReg = 1; regWrite = 1; writeReg = 5'd3; aluResult = 32'hFFFF_0000; memData = 32'h0101_0101;
    step();
    compared++;
    if ({rfWriteEn, rfWriteAddr, rfWriteData, missFlag} !== {1'b1, 5'd3, 32'h0101_0101, 1'b0}) begin
      mismatched++;
      $display("FAIL load_hit: got en=%b addr=%0d data=%h miss=%b, required 1 3 01010101 0",
               rfWriteEn, rfWriteAddr, rfWriteData, missFlag);
    end
    idle_inputs();
    step();
    compared++;
    if (commitCount !== c0 + 16'd1) begin
      mismatched++;
      $display("FAIL load_hit_count: got %0d, required %0d", commitCount, c0 + 16'd1);
    end
  endtask

  task automatic test_load_miss();
    run_to_slot();
    memToReg = 1; regWrite = 1; writeReg = 5'd7; memData = 32'hDEAD_BEEF;
    step();
    compared++;
    if ({rfWriteEn, rfWriteAddr, rfWriteData, missFlag} !== {1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1}) begin
      mismatched++;
      $display("FAIL load_miss: got en=%b addr=%0d data=%h miss=%b, required 1 7 deadbeef 1",
               rfWriteEn, rfWriteAddr, rfWriteData, missFlag);
    end
    run_to_slot();
    regWrite = 1; writeReg = 5'd8; aluResult = 32'h55;
    step(); step(); step();
    compared++;
    if (missFlag !== 1'b1) begin
      mismatched++;
      $display("FAIL miss_sticky: got miss=%b, required 1", missFlag);
    end
  endtask

  task automatic test_no_write();
    logic [15:0] c0;
    run_to_slot();
    c0 = commitCount;
    regWrite = 1; writeReg = 5'd31; aluResult = 32'h99;
    step();
    compared++;
    if (rfWriteEn !== 1'b0) begin
      mismatched++;
      $display("FAIL xzr_write: got en=%b, required 0", rfWriteEn);
    end
    run_to_slot();
    regWrite = 0; writeReg = 5'd2; aluResult = 32'h77;
    step();
    compared++;
    if (rfWriteEn !== 1'b0) begin
      mismatched++;
      $display("FAIL nowrite: got en=%b, required 0", rfWriteEn);
    end
    idle_inputs();
    step();
    compared++;
    if (commitCount !== c0) begin
      mismatched++;
      $display("FAIL nowrite_count: got %0d, required %0d", commitCount, c0);
    end
  endtask

  task automatic test_stall();
    run_to_slot();
    stall = 1; regWrite = 1; writeReg = 5'd9; aluResult = 32'h900D;
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if (rfWriteEn !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_hold cycle %0d: got en=%b, required 0", i, rfWriteEn);
      end
    end
    stall = 0;
    step();
    compared++;
    if ({rfWriteEn, rfWriteAddr, rfWriteData} !== {1'b1, 5'd9, 32'h900D}) begin
      mismatched++;
      $display("FAIL stall_release: got en=%b addr=%0d data=%h, required 1 9 0000900d",
               rfWriteEn, rfWriteAddr, rfWriteData);
    end
    writeReg = 5'd10; aluResult = 32'hA0;
    for (int i = 1; i <= 5; i++) begin
      step();
      compared++;
      if (rfWriteEn !== (i == 5)) begin
        mismatched++;
        $display("FAIL stall_realign edge %0d: got en=%b, required %b", i, rfWriteEn, i == 5);
      end
    end
    stall = 1;
    step();
    compared++;
    if (rfWriteEn !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_in_commit: got en=%b, required 0", rfWriteEn);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    run_to_slot();
    regWrite = 1; writeReg = 5'd12; aluResult = 32'hC0DE;
    step();
    reset_n = 0;
    step();
    compared++;
    if ({rfWriteEn, rfWriteAddr, rfWriteData, missFlag, commitCount} !== 55'd0) begin
      mismatched++;
      $display("FAIL reset_mid: got en=%b addr=%0d data=%h miss=%b cnt=%0d, required all zero",
               rfWriteEn, rfWriteAddr, rfWriteData, missFlag, commitCount);
    end
    reset_n = 1;
    for (int i = 1; i <= 5; i++) begin
      step();
      compared++;
      if (rfWriteEn !== (i == 5)) begin
        mismatched++;
        $display("FAIL reset_release edge %0d: got en=%b, required %b", i, rfWriteEn, i == 5);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset_n  = $urandom_range(0, 49) != 0;
      stall    = $urandom_range(0, 4) == 0;
      memToReg = $urandom_range(0, 1);
      regWrite = $urandom_range(0, 3) != 0;
      writeReg = $urandom_range(0, 3) == 0 ? 5'd31 : 5'($urandom);
      aluResult = $urandom;
      memData  = $urandom_range(0, 5) == 0 ? 32'hDEAD_BEEF : $urandom;
      if (!memToReg && $urandom_range(0, 2) == 0) memData = 32'hzzzz_zzzz;
      step();
      compared++;
      if (rfWriteEn !== m_en) begin
        mismatched++;
        $display("FAIL rand_en cycle %0d: got %b, required %b", i, rfWriteEn, m_en);
      end
      compared++;
      if (rfWriteAddr !== m_addr) begin
        mismatched++;
        $display("FAIL rand_addr cycle %0d: got %0d, required %0d", i, rfWriteAddr, m_addr);
      end
      compared++;
      if (rfWriteData !== m_data) begin
        mismatched++;
        $display("FAIL rand_data cycle %0d: got %h, required %h", i, rfWriteData, m_data);
      end
      compared++;
      if (missFlag !== m_miss) begin
        mismatched++;
        $display("FAIL rand_miss cycle %0d: got %b, required %b", i, missFlag, m_miss);
      end
      compared++;
      if (commitCount !== 16'(m_cnt)) begin
        mismatched++;
        $display("FAIL rand_count cycle %0d: got %0d, required %0d", i, commitCount, m_cnt);
      end
    end
    reset_n = 1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu_writeback();
    test_load_hit();
    test_load_miss();
    test_no_write();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
